// File: rtl/reset_cond_pkg.sv
// Shared types and constants for the push-button reset conditioner.
package reset_cond_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    ASSERT,
    RELEASE_WAIT
  } rc_state_t;

  // Width of the optional accepted-press counter.
  localparam int unsigned PressCountWidth = 16;

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchronizer with synchronous active-high reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;

  // Two back-to-back flops; meta_q may go metastable, q is the settled copy.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/btn_reset_conditioner.sv
// Debounces the raw reset push-button and produces a minimum-width reset for the core.
// Optional feature macro: RESET_COUNT_EN adds a 16-bit accepted-press counter output.
module btn_reset_conditioner
  import reset_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1024,
  parameter int unsigned HOLD_CYCLES     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       btn_in,
  output logic                       cpu_reset,
  output logic                       press_pulse,
`ifdef RESET_COUNT_EN
  output logic [PressCountWidth-1:0] press_count,
`endif
  output logic                       busy
);

  localparam int unsigned CntMax   = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES
                                                                     : HOLD_CYCLES;
  localparam int unsigned CntWidth = $clog2(CntMax) + 1;
  localparam logic [CntWidth-1:0] DebLast  = CntWidth'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntWidth-1:0] HoldLast = CntWidth'(HOLD_CYCLES - 1);

  rc_state_t           state_q;
  logic [CntWidth-1:0] cnt_q;
  logic                btn_sync;

  sync_2ff u_btn_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (btn_sync)
  );

  // Debounce / hold FSM with one shared counter; reset parks it in ASSERT so the core
  // always sees a full hold plus release debounce after power-up or global reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ASSERT;
      cnt_q       <= '0;
      press_pulse <= 1'b0;
`ifdef RESET_COUNT_EN
      press_count <= '0;
`endif
    end else begin
      press_pulse <= 1'b0;
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (btn_sync) begin
            state_q <= PRESS_WAIT;
          end
        end
        PRESS_WAIT: begin
          if (!btn_sync) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == DebLast) begin
            state_q     <= ASSERT;
            cnt_q       <= '0;
            press_pulse <= 1'b1;
`ifdef RESET_COUNT_EN
            press_count <= press_count + 1'b1;
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ASSERT: begin
          // Button level is ignored here: the hold time is unconditional.
          if (cnt_q == HoldLast) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RELEASE_WAIT: begin
          if (btn_sync) begin
            cnt_q <= '0;
          end else if (cnt_q == DebLast) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ASSERT;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Outputs decoded straight from the state register.
  always_comb begin
    cpu_reset = (state_q == ASSERT) || (state_q == RELEASE_WAIT);
    busy      = (state_q != IDLE);
  end

endmodule
